// File: rtl/blinkt_pkg.sv
// rtl/blinkt_pkg.sv - shared constants and state types for the Blinkt LED bar
package blinkt_pkg;

  localparam logic [31:0] APA102_START = 32'h0000_0000;
  localparam logic [31:0] APA102_END   = 32'hFFFF_FFFF;

  localparam logic [5:0] REG_LED_BASE = 6'h00;
  localparam logic [5:0] REG_UPDATE   = 6'h20;

  localparam int NUM_LEDS = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_LED, ST_END} frame_state_t;

  typedef enum logic [1:0] {SER_IDLE, SER_LOW, SER_HIGH, SER_TAIL} ser_state_t;

endpackage

// File: rtl/send_reg_axis.sv
// rtl/send_reg_axis.sv - AXIS word to APA102 clock/data serializer
module send_reg_axis #(
  parameter int CLK_DIV = 2
) (
  input  logic        axis_aclk,
  input  logic        axis_reset,
  input  logic [31:0] s_axis_data,
  input  logic        s_axis_valid,
  output logic        s_axis_ready,
  output logic        o_led_clk,
  output logic        o_led_data
);
  import blinkt_pkg::*;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  ser_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] shreg_q, shreg_d;
  logic        clk_d, data_d, ready_d;
  logic        div_done;

  assign div_done = (cnt_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = div_done ? 8'd0 : cnt_q + 8'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    clk_d   = o_led_clk;
    data_d  = o_led_data;
    ready_d = s_axis_ready;
    case (state_q)
      SER_IDLE: begin
        cnt_d   = 8'd0;
        ready_d = 1'b1;
        if (s_axis_valid && s_axis_ready) begin
          shreg_d = s_axis_data;
          data_d  = s_axis_data[31];
          bit_d   = 5'd31;
          ready_d = 1'b0;
          state_d = SER_LOW;
        end
      end
      SER_LOW: begin
        if (div_done) begin
          clk_d   = 1'b1;
          state_d = SER_HIGH;
        end
      end
      SER_HIGH: begin
        if (div_done) begin
          clk_d = 1'b0;
          if (bit_q == 5'd0) begin
            data_d  = 1'b0;
            state_d = SER_TAIL;
          end else begin
            // shreg[31] is always the bit currently on the pin
            bit_d   = bit_q - 5'd1;
            shreg_d = {shreg_q[30:0], 1'b0};
            data_d  = shreg_q[30];
            state_d = SER_LOW;
          end
        end
      end
      SER_TAIL: begin
        if (div_done) begin
          ready_d = 1'b1;
          state_d = SER_IDLE;
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q      <= SER_IDLE;
      cnt_q        <= 8'd0;
      bit_q        <= 5'd0;
      shreg_q      <= 32'd0;
      o_led_clk    <= 1'b0;
      o_led_data   <= 1'b0;
      s_axis_ready <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      o_led_clk    <= clk_d;
      o_led_data   <= data_d;
      s_axis_ready <= ready_d;
    end
  end

endmodule

// File: rtl/blinkt_led_bar.sv
// rtl/blinkt_led_bar.sv - Wishbone LED frame registers streaming APA102 frames on AXIS
module blinkt_led_bar #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LEDS   = blinkt_pkg::NUM_LEDS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  s_axis_ready
);
  import blinkt_pkg::*;

  localparam int IDX_W = $clog2(NUM_LEDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

  logic [DATA_WIDTH-1:0] led_reg [NUM_LEDS];

  frame_state_t          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic                  valid_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] beat_word;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [5:0]       byte_off;
  logic [IDX_W-1:0] led_sel;
  logic             wb_req, is_led, is_upd, led_wr, upd_wr, busy;
  logic             unused_bits;

  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;

  // Byte lanes and address bits outside [5:2] play no part in decode
  assign unused_bits = ^{wb_sel_i, wb_adr_i[ADDR_WIDTH-1:6], wb_adr_i[1:0]};

  assign byte_off = {wb_adr_i[5:2], 2'b00};
  assign led_sel  = wb_adr_i[IDX_W+1:2];
  assign is_led   = (byte_off - REG_LED_BASE) < 6'(NUM_LEDS * 4);
  assign is_upd   = (byte_off == REG_UPDATE);
  assign wb_req   = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign led_wr   = wb_req & wb_we_i & is_led;
  assign upd_wr   = wb_req & wb_we_i & is_upd;
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    rd_data = '0;
    if (is_led)
      rd_data = led_reg[led_sel];
    else if (is_upd)
      rd_data = DATA_WIDTH'({pending_q, busy});
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      for (int i = 0; i < NUM_LEDS; i++) led_reg[i] <= '0;
    end else begin
      wb_ack_o <= wb_req;
      wb_dat_o <= (wb_req && !wb_we_i) ? rd_data : '0;
      if (led_wr) led_reg[led_sel] <= wb_dat_i;
    end
  end

  always_comb begin
    beat_word = APA102_START;
    case (state_q)
      ST_LED:  beat_word = led_reg[idx_q];
      ST_END:  beat_word = APA102_END;
      default: beat_word = APA102_START;
    endcase
  end

  // Each beat is loaded live one cycle after the previous one is accepted
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    valid_d   = m_axis_valid;
    data_d    = m_axis_data;
    if (state_q == ST_IDLE) begin
      if (upd_wr) state_d = ST_START;
    end else begin
      if (upd_wr) pending_d = 1'b1;
      if (!m_axis_valid) begin
        valid_d = 1'b1;
        data_d  = beat_word;
      end else if (s_axis_ready) begin
        valid_d = 1'b0;
        case (state_q)
          ST_START: begin
            state_d = ST_LED;
            idx_d   = '0;
          end
          ST_LED: begin
            if (idx_q == LAST_IDX) state_d = ST_END;
            else idx_d = idx_q + IDX_W'(1);
          end
          ST_END: begin
            if (pending_q || upd_wr) begin
              state_d   = ST_START;
              pending_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      m_axis_valid <= valid_d;
      m_axis_data  <= data_d;
    end
  end

endmodule

// File: tb/tb_blinkt_led_bar.sv
// tb/tb_blinkt_led_bar.sv - directed self-checking bench for blinkt_led_bar and send_reg_axis
module tb_blinkt_led_bar;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] wb_adr = '0, wb_dat_w = '0;
  logic [31:0] wb_dat_r;
  logic [3:0]  wb_sel = '0;
  logic        wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0;
  logic        wb_ack, wb_err, wb_rty;
  logic [31:0] m_data;
  logic        m_valid;
  logic        top_ready = 1'b1;

  logic [31:0] ser_data = '0;
  logic        ser_valid = 1'b0;
  logic        ser_ready, led_clk, led_data;

  int checks = 0;
  int failures = 0;
  logic [31:0] beats [$];

  blinkt_led_bar dut (
    .i_clk(clk), .i_rst(rst),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r),
    .wb_we_i(wb_we), .wb_sel_i(wb_sel), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc),
    .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_rty_o(wb_rty),
    .m_axis_data(m_data), .m_axis_valid(m_valid), .s_axis_ready(top_ready)
  );

  send_reg_axis #(.CLK_DIV(2)) ser (
    .axis_aclk(clk), .axis_reset(rst),
    .s_axis_data(ser_data), .s_axis_valid(ser_valid), .s_axis_ready(ser_ready),
    .o_led_clk(led_clk), .o_led_data(led_data)
  );

  always @(posedge clk)
    if (!rst && m_valid && top_ready) beats.push_back(m_data);

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
    wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
    tick;
    check("wr_ack", 32'(wb_ack), 32'd1);
    wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
    tick;
    check("wr_ack_once", 32'(wb_ack), 32'd0);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    wb_adr = adr; wb_sel = 4'hF; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
    tick;
    check("rd_ack", 32'(wb_ack), 32'd1);
    dat = wb_dat_r;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    tick;
    check("rd_ack_once", 32'(wb_ack), 32'd0);
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && beats.size() < n; i++) tick;
    check("beats_reached", 32'(beats.size()), 32'(n));
  endtask

  function automatic logic [31:0] exp_beat(input int i);
    if (i == 0) return 32'h0000_0000;
    if (i == 9) return 32'hFFFF_FFFF;
    return 32'hE022_3344 + 32'(i - 1);
  endfunction

  logic [31:0] rd;
  logic [31:0] sh;
  logic        prev;
  int cyc, last_t, min_iv, max_iv, rises;

  initial begin
    // Reset state
    repeat (3) tick;
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_dat", wb_dat_r, 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_mdata", m_data, 32'd0);
    check("rst_err_rty", 32'({wb_err, wb_rty}), 32'd0);
    check("rst_ser_ready", 32'(ser_ready), 32'd0);
    check("rst_pins", 32'({led_clk, led_data}), 32'd0);
    rst = 1'b0;
    tick;
    check("ser_ready_after_rst", 32'(ser_ready), 32'd1);

    // Serializer: one word, MSB first, half period 2, ready low until tail ends
    ser_data = 32'hE022_3344; ser_valid = 1'b1;
    tick;
    ser_valid = 1'b0;
    check("ser_ready_drop", 32'(ser_ready), 32'd0);
    cyc = 0; last_t = 0; min_iv = 1000; max_iv = 0; rises = 0; prev = 1'b0; sh = '0;
    while (cyc < 400) begin
      tick;
      cyc++;
      if (led_clk !== prev) begin
        if (cyc - last_t < min_iv) min_iv = cyc - last_t;
        if (cyc - last_t > max_iv) max_iv = cyc - last_t;
        last_t = cyc;
        if (led_clk) begin
          rises++;
          sh = {sh[30:0], led_data};
        end
      end
      prev = led_clk;
      if (ser_ready) break;
    end
    check("ser_rises", 32'(rises), 32'd32);
    check("ser_word", sh, 32'hE022_3344);
    check("ser_half_min", 32'(min_iv), 32'd2);
    check("ser_half_max", 32'(max_iv), 32'd2);
    check("ser_ready_cycle", 32'(cyc), 32'd130);
    check("ser_idle_pins", 32'({led_clk, led_data}), 32'd0);

    // LED writes, then UPDATE with sel=0 produces one frame
    for (int i = 0; i < 8; i++) wb_write(32'(i * 4), 32'hE022_3344 + 32'(i), 4'hF);
    check("no_frame_yet", 32'(beats.size()), 32'd0);
    wb_write(32'h20, 32'h1234_5678, 4'h0);
    check("valid_rise", 32'(m_valid), 32'd1);
    check("start_word", m_data, 32'd0);
    wait_beats(10, 200);
    repeat (20) tick;
    check("frame1_len", 32'(beats.size()), 32'd10);
    for (int i = 0; i < 10 && i < beats.size(); i++) check("frame1_beat", beats[i], exp_beat(i));
    check("frame1_valid_low", 32'(m_valid), 32'd0);

    // Readback
    for (int i = 0; i < 8; i++) begin
      wb_read(32'(i * 4), rd);
      check("led_readback", rd, 32'hE022_3344 + 32'(i));
    end
    wb_read(32'h24, rd);
    check("read_0x24", rd, 32'd0);
    wb_read(32'h20, rd);
    check("status_idle", rd, 32'd0);

    // Backpressure for 5 cycles on LED3
    beats.delete();
    wb_write(32'h20, 32'd0, 4'hF);
    for (int i = 0; i < 100 && beats.size() < 4; i++) tick;
    top_ready = 1'b0;
    tick;
    for (int j = 0; j < 5; j++) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", m_data, 32'hE022_3347);
      if (j < 4) tick;
    end
    check("hold_count", 32'(beats.size()), 32'd4);
    top_ready = 1'b1;
    wait_beats(10, 200);
    repeat (20) tick;
    check("frame2_len", 32'(beats.size()), 32'd10);
    for (int i = 0; i < 10 && i < beats.size(); i++) check("frame2_beat", beats[i], exp_beat(i));

    // Two UPDATEs while busy coalesce into one extra frame
    beats.delete();
    wb_write(32'h20, 32'd0, 4'hF);
    wb_write(32'h20, 32'd0, 4'hF);
    wb_write(32'h20, 32'd0, 4'hF);
    wb_read(32'h20, rd);
    check("status_busy_pending", rd, 32'd3);
    wait_beats(20, 300);
    repeat (30) tick;
    check("coalesce_len", 32'(beats.size()), 32'd20);
    for (int i = 0; i < 20 && i < beats.size(); i++) check("coalesce_beat", beats[i], exp_beat(i % 10));
    wb_read(32'h20, rd);
    check("status_after", rd, 32'd0);

    // Reset mid-frame after beat 4, serializer mid-word
    beats.delete();
    ser_data = 32'hFFFF_FFFF; ser_valid = 1'b1;
    wb_write(32'h20, 32'd0, 4'hF);
    ser_valid = 1'b0;
    wait_beats(5, 100);
    check("ser_running", 32'(led_data), 32'd1);
    rst = 1'b1;
    tick;
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_mdata", m_data, 32'd0);
    check("midrst_pins", 32'({led_clk, led_data}), 32'd0);
    check("midrst_ser_ready", 32'(ser_ready), 32'd0);
    tick;
    rst = 1'b0;
    repeat (5) tick;
    check("midrst_no_more_beats", 32'(beats.size()), 32'd5);
    check("midrst_valid_stays_low", 32'(m_valid), 32'd0);
    wb_read(32'h00, rd);
    check("midrst_led0", rd, 32'd0);
    wb_read(32'h20, rd);
    check("midrst_status", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
